hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W).
- Keeps its own per-stage scoreboard records (destination register, Tnew countdown) for E, M and W.
- Compares the D-stage instruction's Tuse against those records to generate the stall/bubble signals and the D- and E-stage forwarding selects.
- Also sequences the multi-cycle mult/div unit with a busy counter, and stalls HI/LO users while that unit is busy.

---
 rtl/hazard_ctrl.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller for a 5-stage MIPS pipeline (F/D/E/M/W).
//
// The controller keeps its own small scoreboard. There is one record per stage
// for E, M and W. Each record holds the destination register and the number of
// cycles left before its result exists (tnew). The D-stage instruction's
// operand deadlines (tuse) are compared against these records to decide whether
// D must stall. The same records also produce the forwarding selects for the D
// and E stages. A busy counter sequences the multi-cycle mult/div unit. While
// that counter runs, a new mult/div or any HI/LO access is held in D.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   d_valid             D holds a real instruction
//   d_rs, d_rt          D source register indices
//   d_tuse_rs/_rt       stage offset where the operand is consumed (3 = unused)
//   d_wa, d_tnew        D destination register (0 = none) and its result latency
//   d_md_start/_div     D is mult/multu (div=0) or div/divu (div=1)
//   d_md_use            D reads or writes HI/LO
//   stall, pc_en, fd_en, de_clr   hazard stall and derived pipeline controls
//   fwd_d_rs/_rt        D operand source: 0 regfile, 1 E, 2 M, 3 W
//   fwd_e_rs/_rt        E operand source: 0 D/E register, 1 M, 2 W
//   md_busy             mult/div unit busy (registered)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    output logic       stall,
    output logic       pc_en,
    output logic       fd_en,
    output logic       de_clr,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       md_busy
);

    // Stage records
    logic             e_valid_r;
    logic [4:0]       e_wa_r;
    logic [1:0]       e_tnew_r;
    logic [4:0]       e_rs_r;
    logic [4:0]       e_rt_r;
    logic             m_valid_r;
    logic [4:0]       m_wa_r;
    logic [1:0]       m_tnew_r;
    logic             w_valid_r;
    logic [4:0]       w_wa_r;
    logic [1:0]       w_tnew_r;

    // mult/div sequencing
    logic [CNT_W-1:0] md_cnt_r;
    logic [CNT_W-1:0] md_cnt_nxt_s;
    logic             md_busy_r;
    logic             md_issue_s;

    // Hazard terms
    logic             stall_rs_s;
    logic             stall_rt_s;
    logic             stall_md_s;
    logic             stall_s;
    logic [1:0]       fwd_d_rs_s;
    logic [1:0]       fwd_d_rt_s;
    logic [1:0]       fwd_e_rs_s;
    logic [1:0]       fwd_e_rt_s;

    // Saturating countdown applied each time a record moves down the pipe.
    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : (t - 2'd1);
    endfunction

    // A record produces register r; register 0 is never a real producer.
    function automatic logic rec_match(input logic v, input logic [4:0] wa,
                                       input logic [4:0] r);
        return v && (wa == r) && (r != 5'd0);
    endfunction

    // Operand stall: a producer in E or M whose result is later than the
    // consumer's deadline. W results always exist, so W never stalls.
    function automatic logic op_stall(input logic [4:0] r, input logic [1:0] tuse,
                                      input logic ev, input logic [4:0] ewa,
                                      input logic [1:0] et, input logic mv,
                                      input logic [4:0] mwa, input logic [1:0] mt);
        logic s;
        if (tuse == 2'd3) begin
            s = 1'b0;
        end else begin
            s = (rec_match(ev, ewa, r) && (et > tuse)) ||
                (rec_match(mv, mwa, r) && (mt > tuse));
        end
        return s;
    endfunction

    // D-stage source: nearest producer wins; it only forwards once ready,
    // otherwise the regfile select is kept (a stall covers that case).
    function automatic logic [1:0] d_sel(input logic [4:0] r,
                                         input logic ev, input logic [4:0] ewa,
                                         input logic [1:0] et, input logic mv,
                                         input logic [4:0] mwa, input logic [1:0] mt,
                                         input logic wv, input logic [4:0] wwa,
                                         input logic [1:0] wt);
        logic [1:0] sel;
        if (r == 5'd0) begin
            sel = 2'd0;
        end else if (rec_match(ev, ewa, r)) begin
            sel = (et == 2'd0) ? 2'd1 : 2'd0;
        end else if (rec_match(mv, mwa, r)) begin
            sel = (mt == 2'd0) ? 2'd2 : 2'd0;
        end else if (rec_match(wv, wwa, r)) begin
            sel = (wt == 2'd0) ? 2'd3 : 2'd0;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // E-stage source: same rule as D, looking only at M and W.
    function automatic logic [1:0] e_sel(input logic ev, input logic [4:0] r,
                                         input logic mv, input logic [4:0] mwa,
                                         input logic [1:0] mt, input logic wv,
                                         input logic [4:0] wwa, input logic [1:0] wt);
        logic [1:0] sel;
        if (!ev || (r == 5'd0)) begin
            sel = 2'd0;
        end else if (rec_match(mv, mwa, r)) begin
            sel = (mt == 2'd0) ? 2'd1 : 2'd0;
        end else if (rec_match(wv, wwa, r)) begin
            sel = (wt == 2'd0) ? 2'd2 : 2'd0;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    // Stall decision for the D-stage instruction.
    always_comb begin
        stall_rs_s = 1'b0;
        stall_rt_s = 1'b0;
        stall_md_s = 1'b0;
        if (d_valid) begin
            stall_rs_s = op_stall(d_rs, d_tuse_rs, e_valid_r, e_wa_r, e_tnew_r,
                                  m_valid_r, m_wa_r, m_tnew_r);
            stall_rt_s = op_stall(d_rt, d_tuse_rt, e_valid_r, e_wa_r, e_tnew_r,
                                  m_valid_r, m_wa_r, m_tnew_r);
            stall_md_s = (d_md_start || d_md_use) && (md_cnt_r != {CNT_W{1'b0}});
        end else begin
            stall_rs_s = 1'b0;
            stall_rt_s = 1'b0;
            stall_md_s = 1'b0;
        end
        stall_s = stall_rs_s || stall_rt_s || stall_md_s;
    end

    // Forwarding selects for D and E operands.
    always_comb begin
        fwd_d_rs_s = d_sel(d_rs, e_valid_r, e_wa_r, e_tnew_r, m_valid_r, m_wa_r,
                           m_tnew_r, w_valid_r, w_wa_r, w_tnew_r);
        fwd_d_rt_s = d_sel(d_rt, e_valid_r, e_wa_r, e_tnew_r, m_valid_r, m_wa_r,
                           m_tnew_r, w_valid_r, w_wa_r, w_tnew_r);
        fwd_e_rs_s = e_sel(e_valid_r, e_rs_r, m_valid_r, m_wa_r, m_tnew_r,
                           w_valid_r, w_wa_r, w_tnew_r);
        fwd_e_rt_s = e_sel(e_valid_r, e_rt_r, m_valid_r, m_wa_r, m_tnew_r,
                           w_valid_r, w_wa_r, w_tnew_r);
    end

    // Next value of the mult/div busy counter. An issue can only happen when
    // the counter is already zero, because a busy unit stalls mult/div in D.
    always_comb begin
        md_issue_s   = d_valid && d_md_start && !stall_s;
        md_cnt_nxt_s = md_cnt_r;
        if (md_issue_s) begin
            md_cnt_nxt_s = d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else if (md_cnt_r != {CNT_W{1'b0}}) begin
            md_cnt_nxt_s = md_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            md_cnt_nxt_s = {CNT_W{1'b0}};
        end
    end

    // Scoreboard shift. A stalled D becomes a bubble in E. tnew is loaded
    // unmodified on E entry and counts down on every later move.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_valid_r <= 1'b0;
            e_wa_r    <= 5'd0;
            e_tnew_r  <= 2'd0;
            e_rs_r    <= 5'd0;
            e_rt_r    <= 5'd0;
            m_valid_r <= 1'b0;
            m_wa_r    <= 5'd0;
            m_tnew_r  <= 2'd0;
            w_valid_r <= 1'b0;
            w_wa_r    <= 5'd0;
            w_tnew_r  <= 2'd0;
        end else begin
            if (stall_s) begin
                e_valid_r <= 1'b0;
                e_wa_r    <= 5'd0;
                e_tnew_r  <= 2'd0;
                e_rs_r    <= 5'd0;
                e_rt_r    <= 5'd0;
            end else begin
                e_valid_r <= d_valid;
                e_wa_r    <= d_wa;
                e_tnew_r  <= d_tnew;
                e_rs_r    <= d_rs;
                e_rt_r    <= d_rt;
            end
            m_valid_r <= e_valid_r;
            m_wa_r    <= e_wa_r;
            m_tnew_r  <= dec_sat(e_tnew_r);
            w_valid_r <= m_valid_r;
            w_wa_r    <= m_wa_r;
            w_tnew_r  <= dec_sat(m_tnew_r);
        end
    end

    // mult/div counter and its registered busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt_r  <= {CNT_W{1'b0}};
            md_busy_r <= 1'b0;
        end else begin
            md_cnt_r  <= md_cnt_nxt_s;
            md_busy_r <= (md_cnt_nxt_s != {CNT_W{1'b0}});
        end
    end

    assign stall    = stall_s;
    assign pc_en    = ~stall_s;
    assign fd_en    = ~stall_s;
    assign de_clr   = stall_s;
    assign fwd_d_rs = fwd_d_rs_s;
    assign fwd_d_rt = fwd_d_rt_s;
    assign fwd_e_rs = fwd_e_rs_s;
    assign fwd_e_rt = fwd_e_rt_s;
    assign md_busy  = md_busy_r;

endmodule
